// File: rtl/fir_bus_pkg.sv
// Shared types and constants for the FIR host-bus decoder and its address map.
package fir_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd1,
    StRd2,
    StAck,
    StHold
  } state_e;

  localparam logic REGION_RAM = 1'b0;
  localparam logic REGION_REG = 1'b1;

  localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/fir_addr_map.sv
// Combinational decode of a host address into region, channel, coefficient index and
// register index, plus a flag saying whether the target actually exists.
module fir_addr_map
  import fir_bus_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned COEF_AW  = 5,
  parameter int unsigned REG_AW   = 3,
  parameter int unsigned NUM_REGS = 6,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned ADDR_W  = 1 + CH_W + COEF_AW
) (
  input  logic [ADDR_W-1:0]  addr_i,
  output logic               region_o,
  output logic [CH_W-1:0]    ch_o,
  output logic [COEF_AW-1:0] coef_idx_o,
  output logic [REG_AW-1:0]  reg_idx_o,
  output logic               valid_o
);

  always_comb begin
    region_o   = addr_i[ADDR_W-1];
    ch_o       = addr_i[COEF_AW +: CH_W];
    coef_idx_o = addr_i[COEF_AW-1:0];
    reg_idx_o  = addr_i[REG_AW-1:0];
    // Non-power-of-two channel counts and partial register files leave holes in the map.
    if (region_o == REGION_RAM) begin
      valid_o = 32'(ch_o) < NUM_CH;
    end else begin
      valid_o = 32'(reg_idx_o) < NUM_REGS;
    end
  end

endmodule

// File: rtl/fir_bus_decoder.sv
// Sequential host-bus decoder: turns level read/write requests into single-cycle strobes to
// one coefficient bank or the register file, and returns a one-cycle ack with read data.
module fir_bus_decoder
  import fir_bus_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned COEF_AW  = 5,
  parameter int unsigned REG_AW   = 3,
  parameter int unsigned NUM_REGS = 6,
  parameter int unsigned DATA_W   = 16,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned ADDR_W  = 1 + CH_W + COEF_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      cdc_a,
  input  logic                   cdc_wr,
  input  logic                   cdc_rd,
  input  logic [DATA_W-1:0]      cdc_wdata,
  output logic                   cdc_ack,
  output logic                   cdc_err,
  output logic [DATA_W-1:0]      cdc_rdata,
  output logic [COEF_AW-1:0]     ram_addr,
  output logic [NUM_CH-1:0]      ram_we,
  output logic [NUM_CH-1:0]      ram_re,
  output logic [DATA_W-1:0]      ram_wdata,
  input  logic [NUM_CH*DATA_W-1:0] ram_rdata,
  output logic [REG_AW-1:0]      reg_idx,
  output logic                   reg_we,
  output logic [DATA_W-1:0]      reg_wdata,
  input  logic [DATA_W-1:0]      reg_rdata,
  output logic                   rd_mux_sel,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  logic               dec_region;
  logic [CH_W-1:0]    dec_ch;
  logic [COEF_AW-1:0] dec_coef;
  logic [REG_AW-1:0]  dec_reg;
  logic               dec_valid;
  logic [NUM_CH-1:0]  dec_onehot;
  logic               req;
  logic               req_err;
  logic [DATA_W-1:0]  rd_slice;

  state_e               state_q, state_d;
  logic                 region_q, region_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [COEF_AW-1:0]   ram_addr_q, ram_addr_d;
  logic [REG_AW-1:0]    reg_idx_q, reg_idx_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [NUM_CH-1:0]    ram_we_q, ram_we_d;
  logic [NUM_CH-1:0]    ram_re_q, ram_re_d;
  logic                 reg_we_q, reg_we_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 mux_q, mux_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  fir_addr_map #(
    .NUM_CH   (NUM_CH),
    .COEF_AW  (COEF_AW),
    .REG_AW   (REG_AW),
    .NUM_REGS (NUM_REGS)
  ) u_addr_map (
    .addr_i     (cdc_a),
    .region_o   (dec_region),
    .ch_o       (dec_ch),
    .coef_idx_o (dec_coef),
    .reg_idx_o  (dec_reg),
    .valid_o    (dec_valid)
  );

  assign req     = cdc_wr | cdc_rd;
  assign req_err = ~dec_valid | (cdc_wr & cdc_rd);

  always_comb begin
    dec_onehot = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      dec_onehot[c] = (32'(dec_ch) == c);
    end
  end

  // Bank read data is taken from the channel latched at request time.
  always_comb begin
    rd_slice = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (32'(ch_q) == c) begin
        rd_slice = ram_rdata[c*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    region_d   = region_q;
    ch_d       = ch_q;
    ram_addr_d = ram_addr_q;
    reg_idx_d  = reg_idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    mux_d      = mux_q;
    err_cnt_d  = err_cnt_q;
    ram_we_d   = '0;
    ram_re_d   = '0;
    reg_we_d   = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          region_d   = dec_region;
          ch_d       = dec_ch;
          ram_addr_d = dec_coef;
          reg_idx_d  = dec_reg;
          wdata_d    = cdc_wdata;
          if (req_err) begin
            state_d = StAck;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
            if (cdc_rd) begin
              rdata_d = '0;
            end
          end else if (cdc_wr) begin
            state_d = StWr;
            if (dec_region == REGION_RAM) begin
              ram_we_d = dec_onehot;
            end else begin
              reg_we_d = 1'b1;
            end
          end else begin
            state_d = StRd1;
            if (dec_region == REGION_RAM) begin
              ram_re_d = dec_onehot;
            end
          end
        end
      end
      StWr: begin
        state_d = StAck;
        ack_d   = 1'b1;
        mux_d   = region_q;
      end
      StRd1: begin
        if (region_q == REGION_REG) begin
          state_d = StAck;
          ack_d   = 1'b1;
          rdata_d = reg_rdata;
          mux_d   = REGION_REG;
        end else begin
          state_d = StRd2;
        end
      end
      StRd2: begin
        state_d = StAck;
        ack_d   = 1'b1;
        rdata_d = rd_slice;
        mux_d   = REGION_RAM;
      end
      StAck: begin
        state_d = StHold;
      end
      StHold: begin
        // Requests are levels; wait for release so one request yields one transaction.
        if (!cdc_wr && !cdc_rd) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      region_q   <= 1'b0;
      ch_q       <= '0;
      ram_addr_q <= '0;
      reg_idx_q  <= '0;
      wdata_q    <= '0;
      ram_we_q   <= '0;
      ram_re_q   <= '0;
      reg_we_q   <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      mux_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      region_q   <= region_d;
      ch_q       <= ch_d;
      ram_addr_q <= ram_addr_d;
      reg_idx_q  <= reg_idx_d;
      wdata_q    <= wdata_d;
      ram_we_q   <= ram_we_d;
      ram_re_q   <= ram_re_d;
      reg_we_q   <= reg_we_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      mux_q      <= mux_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign cdc_ack    = ack_q;
  assign cdc_err    = err_q;
  assign cdc_rdata  = rdata_q;
  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_re     = ram_re_q;
  assign ram_wdata  = wdata_q;
  assign reg_idx    = reg_idx_q;
  assign reg_we     = reg_we_q;
  assign reg_wdata  = wdata_q;
  assign rd_mux_sel = mux_q;
  assign err_cnt    = err_cnt_q;

endmodule
